// File: rtl/dekatron_step_ctrl_pkg.sv
// Shared types, command encodings and position helpers for the dekatron
// step controller.
package dekatron_step_ctrl_pkg;

    localparam logic [1:0] CMD_LOAD = 2'b00;
    localparam logic [1:0] CMD_INC  = 2'b01;
    localparam logic [1:0] CMD_DEC  = 2'b10;
    localparam logic [1:0] CMD_CLR  = 2'b11;

    localparam int unsigned DIGIT_MAX = 9;
    localparam int unsigned RING_W    = DIGIT_MAX + 1;
    localparam int unsigned STEP_W    = 3;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_e;

    typedef struct packed {
        logic [STEP_W-1:0] n;
        logic              fwd;
    } step_plan_t;

    function automatic logic [3:0] onehot_to_bcd(input logic [RING_W-1:0] oh);
        logic [3:0] b;
        b = 4'd0;
        for (int i = 0; i < int'(RING_W); i++) begin
            if (oh[i]) b = b | 4'(i);
        end
        return b;
    endfunction

    function automatic logic [RING_W-1:0] bcd_to_onehot(input logic [3:0] b);
        logic [RING_W-1:0] oh;
        oh = '0;
        for (int i = 0; i < int'(RING_W); i++) begin
            if (b == 4'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    // Shortest path around the ring; a half-turn tie resolves forward.
    function automatic step_plan_t plan_steps(input logic [3:0] from, input logic [3:0] to);
        step_plan_t p;
        logic [3:0] d;
        d = (to >= from) ? (to - from) : (to + 4'd10 - from);
        if (d == 4'd0) begin
            p.n   = '0;
            p.fwd = 1'b1;
        end else if (d <= 4'd5) begin
            p.n   = STEP_W'(d);
            p.fwd = 1'b1;
        end else begin
            p.n   = STEP_W'(4'd10 - d);
            p.fwd = 1'b0;
        end
        return p;
    endfunction

endpackage

// File: rtl/dekatron_pulse_timer.sv
// Loadable down-counter marking the last cycle of each pulse or gap phase.
module dekatron_pulse_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign last_c = (count == W'(1));

endmodule

// File: rtl/dekatron_step_ctrl.sv
// Step sequencer for one dekatron digit: plans the shortest path and emits timed
// step pulses. Define DEKATRON_TWO_PHASE_EN for two-phase guide drive.
module dekatron_step_ctrl
    import dekatron_step_ctrl_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              request,
    input  logic [1:0]        cmd,
    input  logic [3:0]        target_bcd,
    output logic              ready,
    output logic              done,
    output logic              error,
`ifdef DEKATRON_TWO_PHASE_EN
    output logic              guide1,
    output logic              guide2,
`else
    output logic              step_fwd,
    output logic              step_back,
`endif
    output logic              carry,
    output logic              borrow,
    output logic [RING_W-1:0] pos_one_hot,
    output logic [3:0]        pos_bcd
);

    localparam int unsigned CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e              state, state_n;
    logic [STEP_W-1:0]   steps, steps_n;
    logic                fwd, fwd_n;
    logic [RING_W-1:0]   pos_n, pos_step;
    logic                ready_n, done_n, error_n, carry_n, borrow_n;
    logic                drv_a, drv_a_n, drv_b, drv_b_n;
    logic                tmr_load, tmr_last, step_end, in_pulse_n;
    logic [CNT_W-1:0]    tmr_val;
    logic [3:0]          tgt;
    logic                tgt_bad;
    step_plan_t          plan;
`ifdef DEKATRON_TWO_PHASE_EN
    logic                ph, ph_n;
`endif

    dekatron_pulse_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .last_c   (tmr_last)
    );

    assign pos_bcd = onehot_to_bcd(pos_one_hot);

    // Command target as a digit; inc/dec wrap around the ring.
    always_comb begin
        tgt = 4'd0;
        case (cmd)
            CMD_LOAD: tgt = target_bcd;
            CMD_INC:  tgt = (pos_bcd == 4'(DIGIT_MAX)) ? 4'd0 : pos_bcd + 4'd1;
            CMD_DEC:  tgt = (pos_bcd == 4'd0) ? 4'(DIGIT_MAX) : pos_bcd - 4'd1;
            default:  tgt = 4'd0;
        endcase
    end

    assign tgt_bad  = (cmd == CMD_LOAD) && (target_bcd > 4'(DIGIT_MAX));
    assign plan     = plan_steps(pos_bcd, tgt);
    assign pos_step = fwd ? {pos_one_hot[RING_W-2:0], pos_one_hot[RING_W-1]}
                          : {pos_one_hot[0], pos_one_hot[RING_W-1:1]};

`ifdef DEKATRON_TWO_PHASE_EN
    assign step_end = tmr_last & ph;
`else
    assign step_end = tmr_last;
`endif

    always_comb begin
        state_n  = state;
        steps_n  = steps;
        fwd_n    = fwd;
        pos_n    = pos_one_hot;
        ready_n  = 1'b0;
        done_n   = 1'b0;
        error_n  = 1'b0;
        carry_n  = 1'b0;
        borrow_n = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = CNT_W'(PULSE_CYCLES);
`ifdef DEKATRON_TWO_PHASE_EN
        ph_n     = ph;
`endif
        unique case (state)
            IDLE: begin
                ready_n = 1'b1;
                if (request) begin
                    if (tgt_bad) begin
                        done_n  = 1'b1;
                        error_n = 1'b1;
                    end else if (plan.n == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n  = PULSE;
                        steps_n  = plan.n;
                        fwd_n    = plan.fwd;
                        tmr_load = 1'b1;
                        ready_n  = 1'b0;
                    end
                end
            end
            PULSE: begin
`ifdef DEKATRON_TWO_PHASE_EN
                if (tmr_last && !ph) begin
                    ph_n     = 1'b1;
                    tmr_load = 1'b1;
                end
`endif
                // Position moves on the final pulse cycle so it is seen in the first gap cycle.
                if (step_end) begin
                    state_n  = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(GAP_CYCLES);
                    pos_n    = pos_step;
                    steps_n  = steps - STEP_W'(1);
                    carry_n  = fwd & pos_one_hot[RING_W-1];
                    borrow_n = ~fwd & pos_one_hot[0];
`ifdef DEKATRON_TWO_PHASE_EN
                    ph_n     = 1'b0;
`endif
                end
            end
            GAP: begin
                if (tmr_last) begin
                    if (steps != '0) begin
                        state_n  = PULSE;
                        tmr_load = 1'b1;
                    end else begin
                        state_n = IDLE;
                        ready_n = 1'b1;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        in_pulse_n = (state_n == PULSE);
`ifdef DEKATRON_TWO_PHASE_EN
        drv_a_n = in_pulse_n & (fwd_n ^ ph_n);
        drv_b_n = in_pulse_n & ~(fwd_n ^ ph_n);
`else
        drv_a_n = in_pulse_n & fwd_n;
        drv_b_n = in_pulse_n & ~fwd_n;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            steps       <= '0;
            fwd         <= 1'b1;
            pos_one_hot <= bcd_to_onehot(4'd0);
            ready       <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            carry       <= 1'b0;
            borrow      <= 1'b0;
            drv_a       <= 1'b0;
            drv_b       <= 1'b0;
`ifdef DEKATRON_TWO_PHASE_EN
            ph          <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            steps       <= steps_n;
            fwd         <= fwd_n;
            pos_one_hot <= pos_n;
            ready       <= ready_n;
            done        <= done_n;
            error       <= error_n;
            carry       <= carry_n;
            borrow      <= borrow_n;
            drv_a       <= drv_a_n;
            drv_b       <= drv_b_n;
`ifdef DEKATRON_TWO_PHASE_EN
            ph          <= ph_n;
`endif
        end
    end

`ifdef DEKATRON_TWO_PHASE_EN
    assign guide1    = drv_a;
    assign guide2    = drv_b;
`else
    assign step_fwd  = drv_a;
    assign step_back = drv_b;
`endif

endmodule

// File: tb/tb_dekatron_step_ctrl.sv
// Self-checking bench for dekatron_step_ctrl: directed table, reset corners and
// randomized commands against a ring-arithmetic reference model.
module tb_dekatron_step_ctrl;
    import dekatron_step_ctrl_pkg::*;

    localparam int P = 2;
    localparam int G = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       request;
    logic [1:0] cmd;
    logic [3:0] target_bcd;
    logic       ready, done, error, step_fwd, step_back, carry, borrow;
    logic [9:0] pos_one_hot;
    logic [3:0] pos_bcd;

    always #5 clk = ~clk;

    dekatron_step_ctrl #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk         (clk),
        .rst         (rst),
        .request     (request),
        .cmd         (cmd),
        .target_bcd  (target_bcd),
        .ready       (ready),
        .done        (done),
        .error       (error),
        .step_fwd    (step_fwd),
        .step_back   (step_back),
        .carry       (carry),
        .borrow      (borrow),
        .pos_one_hot (pos_one_hot),
        .pos_bcd     (pos_bcd)
    );

    typedef struct {
        logic [1:0] c;
        logic [3:0] t;
        int         ep;
        int         en;
        bit         ef;
        int         ecy;
        int         ebo;
        bit         eer;
        bit         poke;
    } vec_t;

    vec_t vecs[12];
    int   tests = 0;
    int   fails = 0;
    int   mpos;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " pos_bcd"}, 32'(pos_bcd), 0);
        check({tag, " pos_one_hot"}, 32'(pos_one_hot), 1);
        check({tag, " ready"}, 32'(ready), 1);
        check({tag, " pulses"}, 32'({done, error, step_fwd, step_back, carry, borrow}), 0);
    endtask

    // Reference: where the digit ends up and how it gets there, from ring arithmetic.
    task automatic model(input logic [1:0] c, input int t, input int p,
                         output int np, output int n, output bit f,
                         output int cy, output int bo, output bit er);
        int tg, d;
        er = 0; cy = 0; bo = 0; f = 1; n = 0; np = p;
        case (c)
            CMD_LOAD: tg = t;
            CMD_INC:  tg = (p + 1) % 10;
            CMD_DEC:  tg = (p + 9) % 10;
            default:  tg = 0;
        endcase
        if (c == CMD_LOAD && t > 9) begin
            er = 1;
        end else begin
            d = (tg - p + 10) % 10;
            if (d == 0) n = 0;
            else if (d <= 5) begin n = d; f = 1; end
            else begin n = 10 - d; f = 0; end
            if (f && (p + n >= 10)) cy = 1;
            if (!f && (p - n < 0)) bo = 1;
            np = tg;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] c, input logic [3:0] t,
                                 input bit poke, input int ep, input int en, input bit ef,
                                 input int ecy, input int ebo, input bit eer);
        int  w, done_k, fcyc, bcyc, fpul, bpul, cyc, boc, errc, both, bad, rbusy, idx;
        logic pf, pb, rdy_done;
        done_k = -1; fcyc = 0; bcyc = 0; fpul = 0; bpul = 0; cyc = 0; boc = 0;
        errc = 0; both = 0; bad = 0; rbusy = 0; pf = 0; pb = 0; rdy_done = 0;
        w = 0;
        while (!ready && w < 100) begin @(negedge clk); w++; end
        check({tag, " ready_before"}, 32'(ready), 1);
        request = 1'b1; cmd = c; target_bcd = t;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            fcyc += int'(step_fwd);
            bcyc += int'(step_back);
            if (step_fwd && !pf) fpul++;
            if (step_back && !pb) bpul++;
            pf = step_fwd; pb = step_back;
            if (step_fwd && step_back) both++;
            cyc  += int'(carry);
            boc  += int'(borrow);
            errc += int'(error);
            idx = -1;
            for (int i = 0; i < 10; i++) if (pos_one_hot[i]) idx = i;
            if ($countones(pos_one_hot) != 1 || int'(pos_bcd) != idx) bad++;
            if (ready && !done) rbusy++;
            request = poke && (k == 3);
            cmd = request ? CMD_INC : c;
            if (done) begin done_k = k; rdy_done = ready; break; end
        end
        request = 1'b0;
        check({tag, " done_latency"}, 32'(done_k), 32'(1 + en * (P + G)));
        check({tag, " error"}, 32'(errc), 32'(eer ? 1 : 0));
        check({tag, " fwd_pulses"}, 32'(fpul), 32'(ef ? en : 0));
        check({tag, " back_pulses"}, 32'(bpul), 32'(ef ? 0 : en));
        check({tag, " pulse_cycles"}, 32'(fcyc + bcyc), 32'(en * P));
        check({tag, " carry"}, 32'(cyc), 32'(ecy));
        check({tag, " borrow"}, 32'(boc), 32'(ebo));
        check({tag, " pos_bcd"}, 32'(pos_bcd), 32'(ep));
        check({tag, " pos_one_hot"}, 32'(pos_one_hot), 32'(1) << ep);
        check({tag, " integrity"}, 32'(both + bad + rbusy), 0);
        check({tag, " ready_at_done"}, 32'(rdy_done), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1);
    end

    initial begin
        int np, n, cy, bo, dcount, scount;
        bit f, er, poke;
        logic [1:0] c;
        int t;

        rst = 1'b1; request = 1'b0; cmd = CMD_LOAD; target_bcd = 4'd0;
        @(negedge clk); @(negedge clk);
        check_reset_vals("por");
        rst = 1'b0; mpos = 0;

        vecs[0]  = '{CMD_LOAD, 4'd3,  3, 3, 1'b1, 0, 0, 1'b0, 1'b0};
        vecs[1]  = '{CMD_LOAD, 4'd8,  8, 5, 1'b1, 0, 0, 1'b0, 1'b0};
        vecs[2]  = '{CMD_LOAD, 4'd1,  1, 3, 1'b1, 1, 0, 1'b0, 1'b0};
        vecs[3]  = '{CMD_LOAD, 4'd7,  7, 4, 1'b0, 0, 1, 1'b0, 1'b0};
        vecs[4]  = '{CMD_LOAD, 4'd12, 7, 0, 1'b1, 0, 0, 1'b1, 1'b0};
        vecs[5]  = '{CMD_CLR,  4'd0,  0, 3, 1'b1, 1, 0, 1'b0, 1'b0};
        vecs[6]  = '{CMD_DEC,  4'd0,  9, 1, 1'b0, 0, 1, 1'b0, 1'b1};
        vecs[7]  = '{CMD_LOAD, 4'd9,  9, 0, 1'b1, 0, 0, 1'b0, 1'b0};
        vecs[8]  = '{CMD_INC,  4'd0,  0, 1, 1'b1, 1, 0, 1'b0, 1'b0};
        vecs[9]  = '{CMD_LOAD, 4'd15, 0, 0, 1'b1, 0, 0, 1'b1, 1'b0};
        vecs[10] = '{CMD_LOAD, 4'd5,  5, 5, 1'b1, 0, 0, 1'b0, 1'b0};
        vecs[11] = '{CMD_LOAD, 4'd0,  0, 5, 1'b1, 1, 0, 1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].c, vecs[i].t, vecs[i].poke,
                          vecs[i].ep, vecs[i].en, vecs[i].ef, vecs[i].ecy, vecs[i].ebo, vecs[i].eer);
        end
        mpos = 0;

        // Reset during the second step pulse of a load 5 from 0.
        request = 1'b1; cmd = CMD_LOAD; target_bcd = 4'd5;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            request = 1'b0;
        end
        check("rst_mid step_fwd", 32'(step_fwd), 1);
        check("rst_mid pos_bcd", 32'(pos_bcd), 1);
        rst = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        dcount = 0; scount = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            dcount += int'(done);
            scount += int'(step_fwd | step_back);
        end
        check("rst_mid no_done", 32'(dcount), 0);
        check("rst_mid no_steps", 32'(scount), 0);
        mpos = 0;
        run_and_check("after_rst", CMD_LOAD, 4'd2, 1'b0, 2, 2, 1'b1, 0, 0, 1'b0);
        mpos = 2;

        for (int i = 0; i < 40; i++) begin
            c = 2'($urandom_range(0, 3));
            t = int'($urandom_range(0, 11));
            poke = ($urandom_range(0, 3) == 0);
            model(c, t, mpos, np, n, f, cy, bo, er);
            run_and_check($sformatf("rnd%0d", i), c, 4'(t), poke, np, n, f, cy, bo, er);
            mpos = np;
        end

        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals("rst_idle");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
